// File: rtl/dma_xfer_engine.sv
// dma_xfer_engine: moves one block of words from src to dst, buffering reads in a FIFO
// and draining them as single-word writes, with rd_done / wr_done completion pulses.
module dma_xfer_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SIZE_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_STEP  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] cfg_src_addr,
    input  logic [ADDR_WIDTH-1:0] cfg_dst_addr,
    input  logic [SIZE_WIDTH-1:0] cfg_size,
    input  logic                  start,
    output logic                  busy,
    output logic                  rd_req,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_gnt,
    input  logic                  rd_rvalid,
    input  logic [DATA_WIDTH-1:0] rd_rdata,
    output logic                  wr_req,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_gnt,
    output logic                  rd_done,
    output logic                  wr_done
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, ZDONE} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
    logic [SIZE_WIDTH-1:0] size_q, size_d;
    logic [SIZE_WIDTH-1:0] rd_issued_q, rd_issued_d, rd_recv_q, rd_recv_d;
    logic [SIZE_WIDTH-1:0] wr_sent_q, wr_sent_d;
    logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  rd_done_q, rd_done_d, wr_done_q, wr_done_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic                  run, launch, rd_fire, push, pop;
    logic [SIZE_WIDTH-1:0] outstanding;
    logic [SIZE_WIDTH:0]   credit;

    assign run         = state_q == RUN;
    assign launch      = state_q == IDLE && start;
    assign outstanding = rd_issued_q - rd_recv_q;
    // words in flight plus words buffered must never exceed the FIFO capacity
    assign credit      = {1'b0, outstanding} + (SIZE_WIDTH+1)'(count_q);
    assign rd_req      = run && rd_issued_q < size_q && credit < (SIZE_WIDTH+1)'(FIFO_DEPTH);
    assign rd_fire     = rd_req && rd_gnt;
    assign push        = run && rd_rvalid && outstanding != '0;
    assign wr_req      = run && count_q != '0;
    assign pop         = wr_req && wr_gnt;
    assign rd_addr     = run ? src_q + ADDR_WIDTH'(rd_issued_q) * ADDR_WIDTH'(ADDR_STEP) : '0;
    assign wr_addr     = run ? dst_q + ADDR_WIDTH'(wr_sent_q) * ADDR_WIDTH'(ADDR_STEP) : '0;
    assign wr_data     = run ? mem_q[rptr_q] : '0;
    assign busy        = state_q != IDLE;
    assign rd_done     = rd_done_q;
    assign wr_done     = wr_done_q;

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        size_d      = size_q;
        rd_issued_d = rd_issued_q;
        rd_recv_d   = rd_recv_q;
        wr_sent_d   = wr_sent_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        rd_done_d   = 1'b0;
        wr_done_d   = 1'b0;
        if (launch) begin
            src_d       = cfg_src_addr;
            dst_d       = cfg_dst_addr;
            size_d      = cfg_size;
            rd_issued_d = '0;
            rd_recv_d   = '0;
            wr_sent_d   = '0;
            wptr_d      = '0;
            rptr_d      = '0;
            count_d     = '0;
            state_d     = cfg_size == '0 ? ZDONE : RUN;
            rd_done_d   = cfg_size == '0;
        end else begin
            rd_issued_d = rd_issued_q + SIZE_WIDTH'(rd_fire);
            rd_recv_d   = rd_recv_q + SIZE_WIDTH'(push);
            wr_sent_d   = wr_sent_q + SIZE_WIDTH'(pop);
            wptr_d      = wptr_q + AW'(push);
            rptr_d      = rptr_q + AW'(pop);
            count_d     = count_q + (AW+1)'(push) - (AW+1)'(pop);
            rd_done_d   = push && rd_recv_d == size_q;
            wr_done_d   = (pop && wr_sent_d == size_q) || (state_q == ZDONE && rd_done_q);
            state_d     = wr_done_q ? IDLE : state_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            size_q      <= '0;
            rd_issued_q <= '0;
            rd_recv_q   <= '0;
            wr_sent_q   <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            rd_done_q   <= 1'b0;
            wr_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            size_q      <= size_d;
            rd_issued_q <= rd_issued_d;
            rd_recv_q   <= rd_recv_d;
            wr_sent_q   <= wr_sent_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            rd_done_q   <= rd_done_d;
            wr_done_q   <= wr_done_d;
        end
    end

    // storage needs no reset: wr_data is masked outside RUN and pointers restart on launch
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= rd_rdata;
    end
endmodule

// File: tb/tb_dma_xfer_engine.sv
// tb_dma_xfer_engine: randomized scoreboard bench; a memory model returns read data in
// order and expected read addresses / write beats are queued from plain address arithmetic.
module tb_dma_xfer_engine;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] cfg_src_addr = '0, cfg_dst_addr = '0;
    logic [15:0] cfg_size = '0;
    logic        start = 1'b0;
    logic        busy, rd_req, wr_req, rd_done, wr_done;
    logic [31:0] rd_addr, wr_addr, wr_data;
    logic        rd_gnt = 1'b0, rd_rvalid = 1'b0, wr_gnt = 1'b0;
    logic [31:0] rd_rdata = '0;

    dma_xfer_engine dut (
        .clk(clk), .rst_n(rst_n), .cfg_src_addr(cfg_src_addr), .cfg_dst_addr(cfg_dst_addr),
        .cfg_size(cfg_size), .start(start), .busy(busy), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_gnt(rd_gnt), .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata), .wr_req(wr_req),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt), .rd_done(rd_done), .wr_done(wr_done)
    );

    typedef struct {logic [31:0] data; int due;} rsp_t;

    int          checks = 0, errors = 0, cyc = 0;
    logic [31:0] exp_rd [$];
    logic [63:0] exp_wr [$];
    rsp_t        rq [$];
    logic [31:0] mem [logic [31:0]];
    int          rd_p = 100, wr_p = 100, lat = 2, cur_size = 0;
    bit          wr_hold = 0, stray = 0, req_seen = 0;
    int          n_rgnt = 0, n_wgnt = 0, n_rv = 0, n_rdone = 0, n_wdone = 0;
    int          rdone_cyc = 0, wdone_cyc = 0;

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // bus agent: grants, ordered read responses, optional stray rvalid
    always @(posedge clk) begin
        #1;
        rd_gnt    = $urandom_range(99) < rd_p;
        wr_gnt    = !wr_hold && $urandom_range(99) < wr_p;
        rd_rvalid = 1'b0;
        if (stray) begin
            rd_rvalid = 1'b1;
            rd_rdata  = $urandom;
        end else if (rq.size() > 0 && rq[0].due <= cyc) begin
            rd_rvalid = 1'b1;
            rd_rdata  = rq[0].data;
            void'(rq.pop_front());
            n_rv++;
        end
    end

    // monitor / scoreboard
    always @(negedge clk) if (rst_n) begin
        if (busy) check("credit", (n_rgnt - n_wgnt) <= 8, 1);
        if (rd_req || wr_req) req_seen = 1;
        if (rd_req && rd_gnt) begin
            rq.push_back('{mem.exists(rd_addr) ? mem[rd_addr] : 32'hDEAD_BEEF, cyc + lat});
            n_rgnt++;
            if (exp_rd.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_extra: got addr %0h expected no request", rd_addr);
            end else check("rd_addr", rd_addr, exp_rd.pop_front());
        end
        if (wr_req && wr_gnt) begin
            n_wgnt++;
            if (exp_wr.size() == 0) begin
                checks++; errors++;
                $display("FAIL wr_extra: got addr %0h data %0h expected no write", wr_addr, wr_data);
            end else check("wr_addr_data", {wr_addr, wr_data}, exp_wr.pop_front());
        end
        if (rd_done || wr_done) check("done_overlap", rd_done && wr_done, 0);
        if (rd_done) begin
            n_rdone++;
            rdone_cyc = cyc;
            check("rd_done_all_data", n_rv, cur_size);
        end
        if (wr_done) begin
            n_wdone++;
            wdone_cyc = cyc;
            check("wr_done_drained", exp_wr.size(), 0);
        end
    end

    task automatic prep(input logic [31:0] src, input logic [31:0] dst, input int size);
        exp_rd.delete();
        exp_wr.delete();
        cur_size = size;
        n_rv = 0; n_rgnt = 0; n_wgnt = 0; n_rdone = 0; n_wdone = 0;
        for (int i = 0; i < size; i++) begin
            logic [31:0] a;
            a = src + 32'(i) * 32'd4;
            mem[a] = $urandom;
            exp_rd.push_back(a);
            exp_wr.push_back({dst + 32'(i) * 32'd4, mem[a]});
        end
    endtask

    task automatic pulse_start(input logic [31:0] src, input logic [31:0] dst, input int size);
        @(posedge clk); #1;
        start = 1'b1; cfg_src_addr = src; cfg_dst_addr = dst; cfg_size = 16'(size);
        @(posedge clk); #1;
        start = 1'b0; cfg_src_addr = $urandom; cfg_dst_addr = $urandom; cfg_size = 16'($urandom);
    endtask

    task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input int size,
                            input int hold, input bit restart);
        int t;
        prep(src, dst, size);
        wr_hold = hold > 0;
        pulse_start(src, dst, size);
        check("busy_rise", busy, 1);
        check("rd_req_first", rd_req, 1);
        if (restart) begin
            repeat (2) @(posedge clk);
            #1 start = 1'b1; cfg_src_addr = 32'hABC0_0000; cfg_dst_addr = 32'h1230_0000; cfg_size = 16'd3;
            @(posedge clk);
            #1 start = 1'b0;
        end
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            #1;
            check("hold_rd_req_low", rd_req, 0);
            check("hold_reads_issued", n_rgnt, 8);
            check("hold_no_writes", n_wgnt, 0);
            wr_hold = 0;
        end
        t = 0;
        while (n_wdone == 0 && t < 3000) begin
            @(negedge clk); #1;
            t++;
        end
        @(negedge clk);
        check("busy_fall", busy, 0);
        check("rd_done_count", n_rdone, 1);
        check("wr_done_count", n_wdone, 1);
        check("rd_before_wr", rdone_cyc < wdone_cyc, 1);
        check("rd_queue_empty", exp_rd.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #1;
        check("reset_outputs", {busy, rd_req, wr_req, rd_done, wr_done, rd_addr, wr_addr, wr_data}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // basic block, always granted, fixed read latency
        rd_p = 100; wr_p = 100; lat = 2;
        run_xfer(32'h100, 32'h200, 4, 0, 0);

        // writes stalled long enough for the credit limit to throttle reads
        run_xfer(32'h1000, 32'h2000, 20, 30, 0);

        // zero length: two pulses, no bus traffic
        prep(32'h40, 32'h80, 0);
        req_seen = 0;
        pulse_start(32'h40, 32'h80, 0);
        @(negedge clk); #1;
        check("z_busy_c1", busy, 1);
        check("z_pulses_c1", {rd_done, wr_done}, 2'b10);
        @(negedge clk); #1;
        check("z_busy_c2", busy, 1);
        check("z_pulses_c2", {rd_done, wr_done}, 2'b01);
        @(negedge clk); #1;
        check("z_busy_c3", busy, 0);
        check("z_no_requests", req_seen, 0);
        check("z_done_counts", {n_rdone[7:0], n_wdone[7:0]}, 16'h0101);

        // source address wraps past the top of the address space
        run_xfer(32'hFFFF_FFF8, 32'h300, 4, 0, 0);

        // reset mid-transfer
        begin
            int t;
            rd_p = 100; wr_p = 100; lat = 2;
            prep(32'h500, 32'h600, 10);
            pulse_start(32'h500, 32'h600, 10);
            t = 0;
            while (n_wgnt < 2 && t < 200) begin
                @(negedge clk); #1;
                t++;
            end
            check("abort_reached_word3", n_wgnt >= 2, 1);
            #1 rst_n = 1'b0;
            #1 check("abort_outputs", {busy, rd_req, wr_req, rd_done, wr_done, rd_addr, wr_addr, wr_data}, 0);
            repeat (2) @(posedge clk);
            rq.delete(); exp_rd.delete(); exp_wr.delete();
            @(negedge clk);
            #2 rst_n = 1'b1;
            repeat (10) @(negedge clk);
            #1;
            check("abort_no_done", {n_rdone[7:0], n_wdone[7:0]}, 0);
            check("abort_idle", busy, 0);
        end
        run_xfer(32'h700, 32'h800, 5, 0, 0);

        // start while busy is ignored; stray rvalid in idle is dropped
        run_xfer(32'h900, 32'hA00, 12, 0, 1);
        @(negedge clk) stray = 1;
        @(negedge clk) stray = 0;
        @(negedge clk); #1;
        check("stray_no_write", wr_req, 0);
        check("stray_idle", busy, 0);
        run_xfer(32'hB00, 32'hC00, 3, 0, 0);

        // randomized traffic
        for (int k = 0; k < 8; k++) begin
            rd_p = $urandom_range(30, 100);
            wr_p = $urandom_range(30, 100);
            lat  = $urandom_range(1, 4);
            run_xfer($urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                     (k == 0) ? 1 : $urandom_range(1, 40), 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
